matvec_datapath_gen: RTL and testbench
======================================

MATVEC_DATAPATH_GEN -- requirements
Module: matvec_datapath_gen

Interface
REQ-001 The block SHALL expose parameter N_LANES, default 8, meaning the number of vector lanes and multipliers (power of 2, 2..32).
REQ-002 The block SHALL expose parameter DW, default 14, meaning the signed operand width.
REQ-003 The block SHALL expose parameter ROWS, default 8, meaning the number of weight rows stored per lane.
REQ-004 The block SHALL expose parameter AW, default 2*DW, meaning the signed product, tree and accumulator width (AW >= 2*DW).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port in_data, input, DW bits: signed write data for the X and W stores.
REQ-008 The block SHALL have ports addr_x (input, $clog2(N_LANES) bits) and wr_en_x (input, 1 bit): X lane select and write strobe.
REQ-009 The block SHALL have ports addr_w (input, $clog2(N_LANES*ROWS) bits) and wr_en_w (input, 1 bit): W address, with the low bits selecting the lane and the high bits the row.
REQ-010 The block SHALL have port issue, input, 1 bit: start one row dot product.
REQ-011 The block SHALL have port row_sel, input, $clog2(ROWS) bits: the W row used on issue.
REQ-012 The block SHALL have ports clear_acc and acc_en, input, 1 bit each: clear the accumulator; add the retiring result to the accumulator (when 0, load it instead).
REQ-013 The block SHALL have ports out_data (output, AW bits, signed) and out_valid (output, 1 bit): the accumulator value and a one-cycle retire strobe.
REQ-014 The block SHALL have port busy, output, 1 bit: high while any issued product is in flight.

Function
REQ-015 Storage and writes:
- X SHALL be N_LANES registers of DW bits; W SHALL be N_LANES x ROWS registers.
- A write SHALL take effect at the edge where its strobe is sampled high; reads are combinational.
REQ-016 Issue capture: the edge sampling issue=1 SHALL capture all N_LANES products X[i]*W[row_sel][i] (full-precision, sign-extended to AW) into stage-0 registers.
REQ-017 Operand stability: X/W writes on or after the issue edge SHALL NOT affect that issue's result.
REQ-018 Adder tree: the block SHALL reduce the products in L=$clog2(N_LANES) levels of pairwise saturating adders, each level registered.
REQ-019 Saturation: every adder SHALL clamp to [-2^(AW-1), 2^(AW-1)-1]; no wrap-around anywhere.
REQ-020 Valid tracking: a valid bit SHALL travel with each issue through stage 0 and the L tree levels; issue SHALL be accepted every cycle, with no stall or backpressure.
REQ-021 Retire: when the valid bit leaves tree level L, the accumulator SHALL update on that edge; out_valid SHALL be high for the following cycle. Issue-to-out_valid latency is L+2 cycles (5 for N_LANES=8).
REQ-022 Accumulator update on retire: acc_en=1 -> acc <= sat(acc + tree); acc_en=0 -> acc <= tree.
REQ-023 clear_acc without retire SHALL set acc to 0 and SHALL NOT assert out_valid.
REQ-024 clear_acc coincident with retire SHALL set acc <= tree, as if cleared first, and SHALL assert out_valid.
REQ-025 out_data SHALL equal the accumulator register at all times.
REQ-026 busy SHALL equal the OR of all pipeline valid bits.

Reset
REQ-027 While rst=0 at a clock edge, all valid bits, out_valid, busy and the accumulator SHALL clear to 0; in-flight issues SHALL be discarded and SHALL never retire.
REQ-028 The X and W stores and the pipeline data registers SHALL NOT be reset.
REQ-029 issue asserted during reset SHALL be ignored.

Structure
REQ-030 A shared package matvec_pkg SHALL hold the default parameter values, the derived constant L, and sat_add/sat_clamp functions.
REQ-031 The block SHALL reuse the existing multiplier and adder_sat modules.
REQ-032 The block SHALL contain one new sub-module, matvec_adder_tree, holding the registered saturating reduction and its valid pipeline.

Verification (N_LANES=8, DW=14, AW=28)
REQ-033 Basic dot product: X=1..8, W row 3 = all 2, issue row 3, acc_en=0 -> out_valid exactly 5 cycles later, out_data=72.
REQ-034 Saturation: X and W row 0 all 8191, acc_en=0 -> out_data=134217727. Then X and W all -8192 -> out_data=134217727, with no wrap.
REQ-035 Back-to-back issue: issue rows 0..7 on consecutive cycles with acc_en=1 -> 8 consecutive out_valid pulses and a running sum; a W write in the cycle after each issue does not alter that result.
REQ-036 Clear collision: clear_acc in the same cycle as a retire of value 40 with acc=100 -> acc=40; clear_acc alone -> acc=0 with out_valid low.
REQ-037 Reset mid-flight: rst=0 for 1 cycle two cycles after issue -> no out_valid follows, busy=0, out_data=0; X/W contents are retained, and a re-issue gives the correct result.

Source files
------------

// File: rtl/matvec_pkg.sv
// Shared constants and saturating arithmetic helpers for the matrix-vector datapath.
package matvec_pkg;

  localparam int N_LANES_DEF = 8;
  localparam int DW_DEF      = 14;
  localparam int ROWS_DEF    = 8;
  localparam int AW_DEF      = 2 * DW_DEF;
  localparam int L           = $clog2(N_LANES_DEF);

  // Widest datapath the helpers support; one extra bit holds an unclamped sum.
  localparam int SAT_W = 64;

  // Clamp a wide signed value into the signed range of a w-bit number.
  function automatic logic signed [SAT_W-1:0] sat_clamp(input logic signed [SAT_W:0] v,
                                                        input int w);
    logic signed [SAT_W:0] one_v;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    one_v = (SAT_W+1)'(1);
    hi    = (one_v <<< (w - 1)) - one_v;
    lo    = -hi - one_v;
    if (v > hi) begin
      return SAT_W'(hi);
    end else if (v < lo) begin
      return SAT_W'(lo);
    end else begin
      return SAT_W'(v);
    end
  endfunction

  // Add two sign-extended w-bit values and clamp the result back into w bits.
  function automatic logic signed [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] a,
                                                      input logic signed [SAT_W-1:0] b,
                                                      input int w);
    logic signed [SAT_W:0] s;
    s = (SAT_W+1)'(a) + (SAT_W+1)'(b);
    return sat_clamp(s, w);
  endfunction

endpackage

// File: rtl/adder_sat.sv
// Combinational W-bit signed adder that clamps instead of wrapping.
module adder_sat
  import matvec_pkg::*;
#(
  parameter int W = 28
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum
);

  assign sum = W'(sat_add(SAT_W'(a), SAT_W'(b), W));

endmodule

// File: rtl/matvec_adder_tree.sv
// Registered pairwise saturating reduction of N values, with a matching valid pipeline.
// Nodes use heap numbering: node k has children 2k+1 and 2k+2, leaves are the inputs,
// so each level pairs adjacent lanes and the root (node 0) appears after log2(N) edges.
module matvec_adder_tree
  import matvec_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [AW-1:0] in_data [N],
  output logic                 out_valid,
  output logic signed [AW-1:0] out_data,
  output logic                 busy
);

  localparam int DEPTH = $clog2(N);

  logic signed [AW-1:0] node_reg [N-1];
  logic signed [AW-1:0] node_sum [N-1];
  logic [DEPTH-1:0]     vld_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N - 1; gi++) begin : g_node
      logic signed [AW-1:0] lhs;
      logic signed [AW-1:0] rhs;
      if (2 * gi + 1 >= N - 1) begin : g_leaf
        assign lhs = in_data[2*gi+1-(N-1)];
        assign rhs = in_data[2*gi+2-(N-1)];
      end else begin : g_inner
        assign lhs = node_reg[2*gi+1];
        assign rhs = node_reg[2*gi+2];
      end
      adder_sat #(.W(AW)) u_add (
        .a  (lhs),
        .b  (rhs),
        .sum(node_sum[gi])
      );
    end
  endgenerate

  // Register every tree node each cycle; data needs no reset since valid gates it.
  always_ff @(posedge clk) begin
    node_reg <= node_sum;
  end

  // Shift the valid bit alongside the data, one stage per tree level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_reg <= '0;
    end else begin
      vld_reg <= DEPTH'({vld_reg, in_valid});
    end
  end

  assign out_valid = vld_reg[DEPTH-1];
  assign out_data  = node_reg[0];
  assign busy      = |vld_reg;

endmodule

// File: rtl/multiplier.sv
// Full-precision signed multiplier, product sign-extended to PW bits.
module multiplier #(
  parameter int DW = 14,
  parameter int PW = 28
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [PW-1:0] p
);

  assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/matvec_datapath_gen.sv
// Matrix-vector row engine: X/W register stores, parallel multiply capture on issue,
// pipelined saturating adder tree and a saturating accumulator with retire strobe.
module matvec_datapath_gen
  import matvec_pkg::*;
#(
  parameter int N_LANES = N_LANES_DEF,
  parameter int DW      = DW_DEF,
  parameter int ROWS    = ROWS_DEF,
  parameter int AW      = 2 * DW
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [DW-1:0]                in_data,
  input  logic [$clog2(N_LANES)-1:0]          addr_x,
  input  logic                                wr_en_x,
  input  logic [$clog2(N_LANES*ROWS)-1:0]     addr_w,
  input  logic                                wr_en_w,
  input  logic                                issue,
  input  logic [$clog2(ROWS)-1:0]             row_sel,
  input  logic                                clear_acc,
  input  logic                                acc_en,
  output logic signed [AW-1:0]                out_data,
  output logic                                out_valid,
  output logic                                busy
);

  localparam int LANE_W = $clog2(N_LANES);

  logic signed [DW-1:0] x_reg [N_LANES];
  logic signed [DW-1:0] w_reg [N_LANES*ROWS];

  logic signed [AW-1:0] prod     [N_LANES];
  logic signed [AW-1:0] prod_reg [N_LANES];
  logic                 v0_reg;

  logic signed [AW-1:0] tree_data;
  logic                 tree_valid;
  logic                 tree_busy;

  logic signed [AW-1:0] acc_reg;
  logic signed [AW-1:0] acc_sum;
  logic                 out_valid_reg;

  // Operand stores keep their contents across reset so a discarded issue can be replayed.
  always_ff @(posedge clk) begin
    if (wr_en_x) begin
      x_reg[addr_x] <= in_data;
    end
    if (wr_en_w) begin
      w_reg[addr_w] <= in_data;
    end
  end

  // One multiplier per lane, reading the selected W row combinationally.
  genvar gi;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
      multiplier #(.DW(DW), .PW(AW)) u_mul (
        .a(x_reg[gi]),
        .b(w_reg[{row_sel, LANE_W'(gi)}]),
        .p(prod[gi])
      );
    end
  endgenerate

  // Capture products on issue; a store write on the same edge still sees old operands here.
  always_ff @(posedge clk) begin
    if (issue) begin
      prod_reg <= prod;
    end
  end

  // Stage-0 valid; issue is ignored while reset is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v0_reg <= 1'b0;
    end else begin
      v0_reg <= issue;
    end
  end

  matvec_adder_tree #(.N(N_LANES), .AW(AW)) u_tree (
    .clk      (clk),
    .rst      (rst),
    .in_valid (v0_reg),
    .in_data  (prod_reg),
    .out_valid(tree_valid),
    .out_data (tree_data),
    .busy     (tree_busy)
  );

  adder_sat #(.W(AW)) u_acc_add (
    .a  (acc_reg),
    .b  (tree_data),
    .sum(acc_sum)
  );

  // Accumulate or load the retiring result; a clear on the retire edge acts as clear-then-load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= tree_valid;
      if (tree_valid) begin
        acc_reg <= (clear_acc || !acc_en) ? tree_data : acc_sum;
      end else if (clear_acc) begin
        acc_reg <= '0;
      end
    end
  end

  assign out_data  = acc_reg;
  assign out_valid = out_valid_reg;
  assign busy      = v0_reg | tree_busy;

endmodule

// File: tb/tb_matvec_datapath_gen.sv
// Scoreboard bench: the driver pushes the expected accumulator value for each issue,
// an independent monitor pops and compares whenever out_valid is seen.
module tb_matvec_datapath_gen;

  localparam int NL    = 8;
  localparam int DW    = 14;
  localparam int ROWS  = 8;
  localparam int AW    = 28;
  localparam int DEPTH = $clog2(NL);
  localparam int LAT   = DEPTH + 2;
  localparam longint MAXV = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint MINV = -MAXV - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [DW-1:0]        in_data = '0;
  logic [2:0]           addr_x = '0;
  logic                 wr_en_x = 1'b0;
  logic [5:0]           addr_w = '0;
  logic                 wr_en_w = 1'b0;
  logic                 issue = 1'b0;
  logic [2:0]           row_sel = '0;
  logic                 clear_acc = 1'b0;
  logic                 acc_en = 1'b0;
  logic signed [AW-1:0] out_data;
  logic                 out_valid;
  logic                 busy;

  matvec_datapath_gen #(.N_LANES(NL), .DW(DW), .ROWS(ROWS), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .addr_x   (addr_x),
    .wr_en_x  (wr_en_x),
    .addr_w   (addr_w),
    .wr_en_w  (wr_en_w),
    .issue    (issue),
    .row_sel  (row_sel),
    .clear_acc(clear_acc),
    .acc_en   (acc_en),
    .out_data (out_data),
    .out_valid(out_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint val;
    int     row;
    int     cyc;
  } exp_t;

  exp_t   q[$];
  longint x_m[NL];
  longint w_m[NL*ROWS];
  longint acc_m = 0;
  bit     exp_clear = 1'b0;
  int     errors = 0;
  int     checks = 0;

  // Reference model: plain arithmetic on the spec's rules.
  function automatic longint sat(longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic longint ref_dot(int row);
    longint lvl[$];
    longint nxt[$];
    for (int i = 0; i < NL; i++) lvl.push_back(x_m[i] * w_m[row*NL+i]);
    while (lvl.size() > 1) begin
      nxt.delete();
      for (int i = 0; i < lvl.size(); i += 2) nxt.push_back(sat(lvl[i] + lvl[i+1]));
      lvl = nxt;
    end
    return lvl[0];
  endfunction

  function automatic int rand_val();
    case ($urandom_range(0, 4))
      0:       return 8191;
      1:       return -8192;
      default: return int'($urandom_range(0, 16383)) - 8192;
    endcase
  endfunction

  // Advance one cycle: predict the issue result, mirror writes, then release strobes.
  task automatic tick();
    longint t;
    exp_t   e;
    if (issue && rst) begin
      t     = ref_dot(int'(row_sel));
      acc_m = (exp_clear || !acc_en) ? t : sat(acc_m + t);
      e.val = acc_m;
      e.row = int'(row_sel);
      e.cyc = cyc;
      q.push_back(e);
    end
    if (wr_en_x) x_m[addr_x] = longint'($signed(in_data));
    if (wr_en_w) w_m[addr_w] = longint'($signed(in_data));
    @(posedge clk);
    #1;
    issue     = 1'b0;
    wr_en_x   = 1'b0;
    wr_en_w   = 1'b0;
    clear_acc = 1'b0;
    exp_clear = 1'b0;
  endtask

  task automatic wx(int lane, int v);
    wr_en_x = 1'b1;
    addr_x  = 3'(lane);
    in_data = DW'(v);
    tick();
  endtask

  task automatic ww(int row, int lane, int v);
    wr_en_w = 1'b1;
    addr_w  = 6'(row * NL + lane);
    in_data = DW'(v);
    tick();
  endtask

  task automatic do_issue(int row);
    issue   = 1'b1;
    row_sel = 3'(row);
    tick();
  endtask

  task automatic check(string name, longint got, longint req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end else begin
      $display("check %s = %0d ok", name, got);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
      q.delete();
    end
    tick();
    tick();
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out_valid got=1 required=0 out_data=%0d", out_data);
        end else begin
          e = q.pop_front();
          if (longint'(out_data) != e.val || (cyc - e.cyc) != LAT) begin
            errors++;
            $display("FAIL retire row=%0d got=%0d required=%0d latency=%0d required=%0d",
                     e.row, out_data, e.val, cyc - e.cyc, LAT);
          end else begin
            $display("retire row=%0d out_data=%0d latency=%0d", e.row, out_data, cyc - e.cyc);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin : driver
    // Reset, with an issue attempt that must be ignored.
    rst = 1'b0;
    tick();
    tick();
    issue = 1'b1;
    tick();
    rst = 1'b1;
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_out_data", longint'(out_data), 0);

    // Fill every store entry with random data.
    for (int i = 0; i < NL; i++) wx(i, rand_val());
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < NL; i++) ww(r, i, rand_val());
    check("no_retire_from_reset_issue", longint'(q.size()), 0);

    // Basic dot product: X=1..8, W row 3 = 2.
    for (int i = 0; i < NL; i++) wx(i, i + 1);
    for (int i = 0; i < NL; i++) ww(3, i, 2);
    acc_en = 1'b0;
    do_issue(3);
    check("busy_inflight", longint'(busy), 1);
    drain();
    check("basic_dot", longint'(out_data), 72);

    // Saturation, positive and negative products.
    for (int i = 0; i < NL; i++) wx(i, 8191);
    for (int i = 0; i < NL; i++) ww(0, i, 8191);
    do_issue(0);
    drain();
    check("sat_pos", longint'(out_data), 134217727);
    for (int i = 0; i < NL; i++) wx(i, -8192);
    for (int i = 0; i < NL; i++) ww(0, i, -8192);
    do_issue(0);
    drain();
    check("sat_negsq", longint'(out_data), 134217727);
    for (int i = 0; i < NL; i++) ww(0, i, 8191);
    do_issue(0);
    drain();
    check("sat_neg", longint'(out_data), -134217728);

    // Clear collision: acc=100, then retire 40 with clear_acc on the retire edge.
    wx(0, 10);
    for (int i = 1; i < NL; i++) wx(i, 0);
    ww(1, 0, 10);
    ww(2, 0, 4);
    acc_en = 1'b0;
    do_issue(1);
    drain();
    check("acc_load_100", longint'(out_data), 100);
    acc_en    = 1'b1;
    exp_clear = 1'b1;
    do_issue(2);
    tick();
    tick();
    tick();
    clear_acc = 1'b1;
    tick();
    drain();
    check("clear_collision", longint'(out_data), 40);
    clear_acc = 1'b1;
    acc_m     = 0;
    tick();
    check("clear_alone_valid", longint'(out_valid), 0);
    tick();
    check("clear_alone_data", longint'(out_data), 0);

    // Back-to-back issues with a W write to the previous row each cycle.
    for (int i = 0; i < NL; i++) wx(i, rand_val());
    acc_en = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      issue   = 1'b1;
      row_sel = 3'(r);
      if (r > 0) begin
        wr_en_w = 1'b1;
        addr_w  = 6'((r - 1) * NL + int'($urandom_range(0, NL - 1)));
        in_data = DW'(rand_val());
      end
      tick();
    end
    drain();
    check("b2b_running_sum", longint'(out_data), acc_m);

    // Reset two cycles after issue discards the in-flight result.
    acc_en = 1'b0;
    do_issue(5);
    tick();
    rst = 1'b0;
    q.delete();
    acc_m = 0;
    tick();
    rst = 1'b1;
    repeat (8) tick();
    check("midreset_busy", longint'(busy), 0);
    check("midreset_out_data", longint'(out_data), 0);
    check("midreset_out_valid", longint'(out_valid), 0);
    do_issue(5);
    drain();

    // Random phases: accumulate, then load, with concurrent store writes.
    for (int ph = 0; ph < 2; ph++) begin
      acc_en = (ph == 0);
      for (int n = 0; n < 30; n++) begin
        issue   = 1'($urandom_range(0, 1));
        row_sel = 3'($urandom_range(0, ROWS - 1));
        case ($urandom_range(0, 2))
          1: begin
            wr_en_x = 1'b1;
            addr_x  = 3'($urandom_range(0, NL - 1));
            in_data = DW'(rand_val());
          end
          2: begin
            wr_en_w = 1'b1;
            addr_w  = 6'($urandom_range(0, NL * ROWS - 1));
            in_data = DW'(rand_val());
          end
          default: ;
        endcase
        tick();
      end
      drain();
      check("random_phase_acc", longint'(out_data), acc_m);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
